muldiv_sequencer: RTL

- Multi-cycle HI/LO unit for the pipelined MIPS core. Sequences an iterative shift-add multiplier and a restoring divider for MULT/MULTU/DIV/DIVU.
- Owns the HI/LO registers and services MTHI/MTLO.
- Sits beside the EX-stage ALU. Its busy output drives the hazard unit so that MFHI/MFLO and new mult/div ops stall until the result is ready.

---
 rtl/muldiv_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle HI/LO unit for MULT/MULTU/DIV/DIVU plus MTHI/MTLO.
// Iterative shift-add multiplier and restoring divider share one 2*WIDTH accumulator.
// Optional build macro MULDIV_DIV0_FLAG_EN: divide-by-zero completes in one cycle
// and raises div0 with done; without it div0 stays 0 and divide-by-zero runs full length.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned ACC_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;    // multiplicand or divisor magnitude
  logic [ACC_W-1:0] acc_q, acc_d;      // product, or remainder:quotient
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_q, neg_d;      // negate product / quotient
  logic             neg_rem_q, neg_rem_d;

  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_trial;
  logic [ACC_W-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0] quot_fix, rem_fix;

  // Operand magnitudes and signs for the op being launched
  always_comb begin
    a_neg  = ~op[0] & a[WIDTH-1];
    b_neg  = ~op[0] & b[WIDTH-1];
    a_mag  = a_neg ? (~a + WIDTH'(1)) : a;
    b_mag  = b_neg ? (~b + WIDTH'(1)) : b;
    b_zero = (b == '0);
  end

  // Single iteration of shift-add multiply and restoring divide, plus sign fix-up
  always_comb begin
    mul_sum   = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_trial = acc_q[ACC_W-1:WIDTH-1] - {1'b0, opnd_q};
    if (!div_trial[WIDTH]) begin
      div_next = {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {acc_q[ACC_W-2:0], 1'b0};
    end
    prod_fix = neg_q ? (~acc_q + ACC_W'(1)) : acc_q;
    quot_fix = neg_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? (~acc_q[ACC_W-1:WIDTH] + WIDTH'(1)) : acc_q[ACC_W-1:WIDTH];
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    div0_d    = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          opnd_d    = op[1] ? b_mag : a_mag;
          acc_d     = op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
          is_div_d  = op[1];
          // b==0 quotient is all ones whatever the dividend sign
          neg_d     = (a_neg ^ b_neg) & ~(op[1] & b_zero);
          neg_rem_d = a_neg;
          cnt_d     = '0;
          state_d   = S_CALC;
`ifdef MULDIV_DIV0_FLAG_EN
          if (op[1] && b_zero) begin
            state_d = S_DONE;
            hi_d    = a;
            lo_d    = '1;
            done_d  = 1'b1;
            div0_d  = 1'b1;
          end
`endif
        end else if (!start) begin
          if (wr_hi) hi_d = wdata;
          if (wr_lo) lo_d = wdata;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = is_div_q ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quot_fix;
          end else begin
            hi_d = prod_fix[ACC_W-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign div0 = div0_q;

endmodule
